pipeline_stall_responder: RTL
=============================

PIPELINE_STALL_RESPONDER -- requirements
Module: pipeline_stall_responder

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter CTRL_W, default 10: width of the ID control bundle.
REQ-003 Parameter WATCHDOG_LIMIT, default 8: consecutive stall cycles that trigger a hang flag.
REQ-004 Clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 PCWrite  input  1  hazard unit: 1 = PC may advance.
REQ-007 IF_ID_Write  input  1  hazard unit: 1 = IF/ID register may load.
REQ-008 ControlMux  input  1  hazard unit: 0 = inject bubble into ID/EX control.
REQ-009 Branch_Taken  input  1  ID-stage branch resolved taken.
REQ-010 Branch_Target  input  32  ID-stage branch target address.
REQ-011 Instr_In  input  32  instruction memory data at PC_Out.
REQ-012 ID_Ctrl_In  input  CTRL_W  main-controller bundle for the instruction in IF/ID.
REQ-013 PC_Out  output  32  current PC.
REQ-014 IF_ID_Instr  output  32  IF/ID instruction.
REQ-015 IF_ID_PCPlus4  output  32  IF/ID PC+4.
REQ-016 IF_ID_Valid  output  1  IF/ID holds a real instruction.
REQ-017 ID_EX_Ctrl  output  CTRL_W  registered ID/EX control bundle.
REQ-018 Stall_Active  output  1  state machine not in RUN.
REQ-019 Stall_Count  output  16  total stall cycles since reset, saturating.
REQ-020 Watchdog_Error  output  1  sticky hang flag.

Function
REQ-021 Advance = PCWrite AND IF_ID_Write; the illegal mix (one high, one low) SHALL freeze both PC and IF/ID.
REQ-022 Effective branch = Branch_Taken AND Advance; Branch_Taken during a stall SHALL be ignored.
REQ-023 PC update: effective branch -> Branch_Target; else Advance -> PC_Out+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0); else hold.
REQ-024 IF/ID update: effective branch -> Instr 0, PCPlus4 0, Valid 0 (flush); else Advance -> Instr_In, PC_Out+4, Valid 1; else hold all three.
REQ-025 ID/EX control: ControlMux=0 or IF_ID_Valid=0 -> all zeros; else ID_Ctrl_In; loaded every cycle, 1-cycle latency.
REQ-026 States RUN, STALL, HUNG; stall cycle = Advance is 0.
REQ-027 RUN -> STALL on a stall cycle; otherwise remain RUN.
REQ-028 STALL: 5-bit consecutive counter increments per stall cycle; -> RUN and counter cleared on the first non-stall cycle; -> HUNG when the counter reaches WATCHDOG_LIMIT.
REQ-029 HUNG is left only by reset; the datapath keeps honouring inputs while in HUNG.
REQ-030 Stall_Active = 1 in STALL and HUNG, registered from state.
REQ-031 Watchdog_Error = 1 exactly while in HUNG.
REQ-032 Stall_Count increments on every stall cycle in any state and saturates at 16'hFFFF with no wrap.

Reset
REQ-033 Reset low, asynchronously and regardless of Clk: PC_Out=RESET_PC; IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl and Stall_Count = 0; state RUN; Watchdog_Error 0.
REQ-034 Reset asserted mid-stall or in HUNG SHALL discard all state; the first rising edge after deassertion SHALL behave as normal RUN operation.

Verification
REQ-035 Reset, then 3 cycles with all hazard inputs 1 and Instr_In=32'h2001_0005 -> PC_Out 0,4,8,12; IF_ID_Valid=1; IF_ID_PCPlus4 tracks PC+4.
REQ-036 PCWrite=IF_ID_Write=ControlMux=0 for 2 cycles at PC=8 -> PC_Out and IF/ID held; ID_EX_Ctrl=0; Stall_Active=1; Stall_Count=2; Stall_Active returns to 0 one cycle after release.
REQ-037 Branch_Taken=1, Branch_Target=32'h40, Advance=1 -> PC_Out=32'h40, IF_ID_Valid=0, next ID_EX_Ctrl=0; repeat with PCWrite=0 -> branch ignored, PC held.
REQ-038 PCWrite=1, IF_ID_Write=0 -> PC and IF/ID both frozen; cycle counted as a stall.
REQ-039 8 consecutive stall cycles -> Watchdog_Error=1 and stays 1 after stall release; Reset pulse mid-cycle -> immediately cleared, PC_Out=RESET_PC.
REQ-040 PC forced to 32'hFFFF_FFFC via branch, then one advance -> PC_Out=0, IF_ID_PCPlus4=0.

Source files
------------

// File: rtl/pipeline_stall_responder_if.sv
// Hazard-unit, fetch and IF/ID-ID/EX pipeline signals of the stall responder.
// The slave modport is the responder's view; master is the driver's view.
interface pipeline_stall_responder_if #(
  parameter int CTRL_W = 10
);
  logic              PCWrite;
  logic              IF_ID_Write;
  logic              ControlMux;
  logic              Branch_Taken;
  logic [31:0]       Branch_Target;
  logic [31:0]       Instr_In;
  logic [CTRL_W-1:0] ID_Ctrl_In;
  logic [31:0]       PC_Out;
  logic [31:0]       IF_ID_Instr;
  logic [31:0]       IF_ID_PCPlus4;
  logic              IF_ID_Valid;
  logic [CTRL_W-1:0] ID_EX_Ctrl;
  logic              Stall_Active;
  logic [15:0]       Stall_Count;
  logic              Watchdog_Error;

  modport slave (
    input  PCWrite, IF_ID_Write, ControlMux, Branch_Taken, Branch_Target,
           Instr_In, ID_Ctrl_In,
    output PC_Out, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl,
           Stall_Active, Stall_Count, Watchdog_Error
  );

  modport master (
    output PCWrite, IF_ID_Write, ControlMux, Branch_Taken, Branch_Target,
           Instr_In, ID_Ctrl_In,
    input  PC_Out, IF_ID_Instr, IF_ID_PCPlus4, IF_ID_Valid, ID_EX_Ctrl,
           Stall_Active, Stall_Count, Watchdog_Error
  );
endinterface

// File: rtl/pipeline_stall_responder.sv
// PC / IF-ID / ID-EX front end that obeys hazard-unit stalls, flushes on taken
// branches, counts stall cycles and latches a watchdog flag on a stuck pipeline.
module pipeline_stall_responder #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          CTRL_W         = 10,
  parameter int          WATCHDOG_LIMIT = 8
) (
  input  logic                          Clk,
  input  logic                          Reset,
  pipeline_stall_responder_if.slave     bus
);
  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    HUNG  = 2'd2
  } state_e;

  localparam logic [4:0] LIMIT_C = 5'(WATCHDOG_LIMIT);

  state_e            state_q, state_d;
  logic [4:0]        consec_q, consec_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instr_q, instr_d;
  logic [31:0]       pcplus4_q, pcplus4_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [15:0]       stall_cnt_q, stall_cnt_d;
  logic              stall_active_q;
  logic              wdog_q;

  logic        advance_s;
  logic        branch_s;
  logic [31:0] pc_plus4_s;

  assign advance_s  = bus.PCWrite & bus.IF_ID_Write;
  assign branch_s   = bus.Branch_Taken & advance_s;
  assign pc_plus4_s = pc_q + 32'd4;

  // Datapath next state: PC, IF/ID, ID/EX control and total stall counter.
  always_comb begin
    pc_d        = pc_q;
    instr_d     = instr_q;
    pcplus4_d   = pcplus4_q;
    valid_d     = valid_q;
    stall_cnt_d = stall_cnt_q;
    if (branch_s) begin
      pc_d      = bus.Branch_Target;
      instr_d   = 32'h0000_0000;
      pcplus4_d = 32'h0000_0000;
      valid_d   = 1'b0;
    end else if (advance_s) begin
      pc_d      = pc_plus4_s;
      instr_d   = bus.Instr_In;
      pcplus4_d = pc_plus4_s;
      valid_d   = 1'b1;
    end else begin
      pc_d      = pc_q;
    end
    if (!bus.ControlMux || !valid_q) begin
      ctrl_d = '0;
    end else begin
      ctrl_d = bus.ID_Ctrl_In;
    end
    // Saturate rather than wrap so a long hang never looks like a short one.
    if (!advance_s && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Stall-tracking FSM next state and consecutive-stall counter.
  always_comb begin
    state_d  = state_q;
    consec_d = consec_q;
    case (state_q)
      RUN: begin
        if (!advance_s) begin
          consec_d = 5'd1;
          state_d  = (5'd1 >= LIMIT_C) ? HUNG : STALL;
        end else begin
          consec_d = 5'd0;
          state_d  = RUN;
        end
      end
      STALL: begin
        if (!advance_s) begin
          consec_d = consec_q + 5'd1;
          state_d  = ((consec_q + 5'd1) >= LIMIT_C) ? HUNG : STALL;
        end else begin
          consec_d = 5'd0;
          state_d  = RUN;
        end
      end
      HUNG: begin
        consec_d = consec_q;
        state_d  = HUNG;
      end
      default: begin
        consec_d = 5'd0;
        state_d  = RUN;
      end
    endcase
  end

  // State and pipeline registers with asynchronous active-low reset.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= RUN;
      consec_q       <= 5'd0;
      pc_q           <= RESET_PC;
      instr_q        <= 32'h0000_0000;
      pcplus4_q      <= 32'h0000_0000;
      valid_q        <= 1'b0;
      ctrl_q         <= '0;
      stall_cnt_q    <= 16'h0000;
      stall_active_q <= 1'b0;
      wdog_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      consec_q       <= consec_d;
      pc_q           <= pc_d;
      instr_q        <= instr_d;
      pcplus4_q      <= pcplus4_d;
      valid_q        <= valid_d;
      ctrl_q         <= ctrl_d;
      stall_cnt_q    <= stall_cnt_d;
      stall_active_q <= (state_d != RUN);
      wdog_q         <= (state_d == HUNG);
    end
  end

  assign bus.PC_Out         = pc_q;
  assign bus.IF_ID_Instr    = instr_q;
  assign bus.IF_ID_PCPlus4  = pcplus4_q;
  assign bus.IF_ID_Valid    = valid_q;
  assign bus.ID_EX_Ctrl     = ctrl_q;
  assign bus.Stall_Active   = stall_active_q;
  assign bus.Stall_Count    = stall_cnt_q;
  assign bus.Watchdog_Error = wdog_q;
endmodule
